// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared sizes, entry layout and helpers for the store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_PC_W  = 32;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  localparam int SB_CNT_W = SB_PTR_W + 1;

  // One queued store: word address (byte offset dropped), data and the store's PC.
  typedef struct packed {
    logic [SB_AW-3:0]   waddr;
    logic [SB_DW-1:0]   data;
    logic [SB_PC_W-1:0] pc;
  } sb_entry_t;

  // The memory's write trace expects PC+8 of the store instruction.
  function automatic logic [SB_PC_W-1:0] pc_plus8(input logic [SB_PC_W-1:0] pc);
    return pc + SB_PC_W'(8);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - finds the youngest queued store whose word address matches a load
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-3:0] waddr_i,
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [AW-1:0]            ld_addr_i,
  output logic                     hit_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  // Walk entries oldest to youngest starting at head; a later match overrides an
  // earlier one, so the surviving index is the match closest to tail-1.
  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PTR_W'(k);
      if (valid_i[slot] && (waddr_i[slot] == ld_addr_i[AW-1:2])) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store queue with load forwarding in front of data memory
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [31:0]   st_pc,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          stall,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wd,
  output logic          dm_we,
  output logic [31:0]   dm_pc8,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][AW-3:0] waddr_q;
  logic [DW-1:0]            data_q [DEPTH];
  logic [31:0]              pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             empty, full, push, pop;
  logic [DEPTH-1:0] valid_mask;
  logic [PTR_W-1:0] age;
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A load owns the memory port, so the head only drains on load-free ready cycles.
  assign pop   = !empty && !ld_valid && dm_ready;
  // A full queue still accepts a store when the head leaves in the same cycle.
  assign push  = st_valid && (!full || pop);
  assign stall = st_valid && full && !pop;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid_mask = '0;
    age        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age           = PTR_W'(i) - head_q;
      valid_mask[i] = ({1'b0, age} < count_q);
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .valid_i   (valid_mask),
    .waddr_i   (waddr_q),
    .head_i    (head_q),
    .ld_addr_i (ld_addr),
    .hit_o     (fwd_hit),
    .idx_o     (fwd_idx)
  );

  assign ld_data = fwd_hit ? data_q[fwd_idx] : dm_rdata;

  // Memory port: the load address wins; otherwise present the head store.
  assign dm_addr = ld_valid ? ld_addr : {waddr_q[head_q], 2'b00};
  assign dm_wd   = data_q[head_q];
  assign dm_pc8  = pc_plus8(pc_q[head_q]);
  assign dm_we   = pop;

  // Next pointer and occupancy values.
  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Queue control state; reset discards every queued store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload write at tail; contents need no reset because the count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= st_addr[AW-1:2];
      data_q[tail_q]  <= st_data;
      pc_q[tail_q]    <= st_pc;
    end
  end

endmodule
